regfile_mp: RTL
===============

// Module: regfile_mp
//
// PURPOSE
// Multi-port register file: generalised successor of the single-port regfile.
// Provides N_RD read ports and N_WR write ports with byte enables and optional
// registered reads with write-to-read bypass.
// Provides synchronous clear and optional hard-wired zero entry 0 (RISC-style).
// Intended for CPU register files and small config/state tables.
//
// PARAMETERS
// N_ENTRIES   32  number of entries, >=2, need not be a power of 2
// DWIDTH      32  entry width in bits, multiple of 8
// N_RD        2   number of read ports, >=1
// N_WR        1   number of write ports, >=1
// RD_LATENCY  1   0 = combinational read, 1 = registered read
// BYPASS      1   1 = write-first (reads see same-cycle writes), 0 = read-first
// ZERO_REG0   0   1 = entry 0 reads as 0 and ignores writes
// (derived) AW = $clog2(N_ENTRIES), BW = DWIDTH/8
//
// PORTS
// clk          in   1            clock, rising edge
// rst_n        in   1            reset, asynchronous, active-low
// clr          in   1            synchronous clear of all entries
// wr_en        in   N_WR         per-port write enable
// wr_addr      in   N_WR x AW    write address
// wr_data      in   N_WR x DWIDTH write data
// wr_be        in   N_WR x BW    byte enables, bit b gates bits [8b+7:8b]
// rd_en        in   N_RD         per-port read request
// rd_addr      in   N_RD x AW    read address
// rd_data      out  N_RD x DWIDTH read data
// rd_valid     out  N_RD         rd_data valid
// wr_conflict  out  1            registered pulse: >=2 ports wrote one address
//
// BEHAVIOUR
// - Reset (rst_n low, async): all entries, rd_data, rd_valid and wr_conflict are 0.
//   Reset asserted mid-operation clears them immediately and discards pending reads.
// - Write: at posedge, each port with wr_en=1 updates only the bytes enabled by wr_be.
//   wr_be=0 writes nothing.
// - Same-address multi-write: resolved per byte; highest port index wins.
//   wr_conflict=1 for exactly the next cycle when any two enabled ports share an
//   address (any be).
// - Address >= N_ENTRIES: write dropped; read returns 0.
// - ZERO_REG0=1: writes to entry 0 are dropped (no conflict counted); reads return 0.
// - clr=1: all entries are 0 after the edge; clr overrides all writes that cycle.
// - RD_LATENCY=0: rd_data = entry contents, combinational; rd_valid = rd_en.
//   With BYPASS=1, enabled same-cycle writes are merged combinationally.
// - RD_LATENCY=1: at posedge with rd_en=1, rd_data loads and rd_valid goes to 1
//   next cycle.
//   BYPASS=1: loaded value = entry after this edge's writes/clr.
//   BYPASS=0: loaded value = entry before the edge.
//   rd_en=0: rd_data holds its last value and rd_valid goes to 0.
// - Read ports are fully independent; any number may read one address.
//
// STRUCTURE
// - Package regfile_pkg holds the rd_latency_e enum (RD_COMB, RD_REG).
// - regfile_pkg also holds function be_merge(old, new, be) -> merged word.
// - Sub-module regfile_wr_merge: per-entry next-value logic.
//   Inputs: current value, all write ports, clr. Outputs: next value, hit flags.
//   Instantiated in a generate loop over entries; hit flags also feed
//   conflict detection and bypass.
//
// TESTING
// 1. Reset: fill all entries with 0xA5A5A5A5, pulse rst_n low mid-write,
//    read all -> 0, rd_valid=0.
// 2. Byte enables: write 0x11223344 be=4'b1111, then 0xFFFFFFFF be=4'b0101
//    -> read 0x11FF33FF.
// 3. Conflict: N_WR=2, port0 writes 0xAAAAAAAA, port1 writes 0x55555555 to addr 5
//    -> 0x55555555, wr_conflict=1 for one cycle.
// 4. Bypass: RD_LATENCY=1, write 0x12345678 to addr 3 and read addr 3 same cycle
//    -> 0x12345678 if BYPASS=1, old value if BYPASS=0.
// 5. Zero register: ZERO_REG0=1, write 0xDEADBEEF to addr 0 -> read 0, no conflict.
//    clr with a same-cycle write to addr 7 -> addr 7 reads 0.
// 6. Range: N_ENTRIES=24, write addr 30 -> no entry changes; read addr 30 -> 0.
//    Random multi-port traffic checked against a reference model.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// be_merge works on a fixed-width word; callers zero-extend and truncate to DWIDTH.
package regfile_pkg;

  typedef enum logic {
    RD_COMB = 1'b0,
    RD_REG  = 1'b1
  } rd_latency_e;

  // Widest entry the merge helper supports; DWIDTH must not exceed it.
  localparam int MAX_DWIDTH = 256;
  localparam int MAX_BW     = MAX_DWIDTH / 8;

  typedef logic [MAX_DWIDTH-1:0] word_t;
  typedef logic [MAX_BW-1:0]     be_t;

  function automatic word_t be_merge(word_t old_w, word_t new_w, be_t be);
    word_t merged;
    merged = old_w;
    for (int b = 0; b < MAX_BW; b++) begin
      if (be[b]) merged[8*b +: 8] = new_w[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/regfile_wr_merge.sv
// Next-value logic for one register entry: byte-enabled writes from all ports,
// applied in ascending port order so the highest port wins each byte; clr wins over all.
module regfile_wr_merge
  import regfile_pkg::*;
#(
  parameter int DWIDTH    = 32,
  parameter int N_WR      = 1,
  parameter int AW        = 5,
  parameter int ENTRY     = 0,
  parameter bit HARD_ZERO = 1'b0,
  localparam int BW       = DWIDTH / 8
) (
  input  logic [DWIDTH-1:0]           i_cur,
  input  logic                        i_clr,
  input  logic [N_WR-1:0]             i_wr_en,
  input  logic [N_WR-1:0][AW-1:0]     i_wr_addr,
  input  logic [N_WR-1:0][DWIDTH-1:0] i_wr_data,
  input  logic [N_WR-1:0][BW-1:0]     i_wr_be,
  output logic [DWIDTH-1:0]           o_next,
  output logic [N_WR-1:0]             o_hit
);

  word_t w_acc;
  word_t w_data_ext;
  be_t   w_be_ext;

  always_comb begin
    o_hit = '0;
    w_acc = '0;
    w_acc[DWIDTH-1:0] = i_cur;
    for (int p = 0; p < N_WR; p++) begin
      w_data_ext = '0;
      w_be_ext   = '0;
      w_data_ext[DWIDTH-1:0] = i_wr_data[p];
      w_be_ext[BW-1:0]       = i_wr_be[p];
      // Hit ignores byte enables: a be=0 write still counts towards a conflict.
      o_hit[p] = i_wr_en[p] && (i_wr_addr[p] == AW'(ENTRY)) && !HARD_ZERO;
      // NOTE: blocking assignments here chain each port's merge onto the previous one.
      if (o_hit[p]) w_acc = be_merge(w_acc, w_data_ext, w_be_ext);
    end
    o_next = (i_clr || HARD_ZERO) ? '0 : w_acc[DWIDTH-1:0];
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: N_WR byte-enabled write ports, N_RD read ports with
// combinational or registered reads, optional write-first bypass and hard-wired zero entry.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int N_ENTRIES  = 32,
  parameter int DWIDTH     = 32,
  parameter int N_RD       = 2,
  parameter int N_WR       = 1,
  parameter int RD_LATENCY = 1,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG0  = 0,
  localparam int AW        = $clog2(N_ENTRIES),
  localparam int BW        = DWIDTH / 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  input  logic [N_WR-1:0]             wr_en,
  input  logic [N_WR-1:0][AW-1:0]     wr_addr,
  input  logic [N_WR-1:0][DWIDTH-1:0] wr_data,
  input  logic [N_WR-1:0][BW-1:0]     wr_be,
  input  logic [N_RD-1:0]             rd_en,
  input  logic [N_RD-1:0][AW-1:0]     rd_addr,
  output logic [N_RD-1:0][DWIDTH-1:0] rd_data,
  output logic [N_RD-1:0]             rd_valid,
  output logic                        wr_conflict
);

  localparam rd_latency_e LAT = (RD_LATENCY != 0) ? RD_REG : RD_COMB;

  logic [DWIDTH-1:0]                  r_mem [N_ENTRIES];
  logic [N_ENTRIES-1:0][DWIDTH-1:0]   w_next;
  logic [N_ENTRIES-1:0][N_WR-1:0]     w_hit;
  logic [N_ENTRIES-1:0]               w_multi;
  logic [N_RD-1:0][DWIDTH-1:0]        w_rd_val;
  logic                               r_conflict;

  // Out-of-range addresses match no entry, so their writes vanish naturally.
  for (genvar e = 0; e < N_ENTRIES; e++) begin : g_entry
    regfile_wr_merge #(
      .DWIDTH    (DWIDTH),
      .N_WR      (N_WR),
      .AW        (AW),
      .ENTRY     (e),
      .HARD_ZERO ((ZERO_REG0 != 0) && (e == 0))
    ) u_merge (
      .i_cur     (r_mem[e]),
      .i_clr     (clr),
      .i_wr_en   (wr_en),
      .i_wr_addr (wr_addr),
      .i_wr_data (wr_data),
      .i_wr_be   (wr_be),
      .o_next    (w_next[e]),
      .o_hit     (w_hit[e])
    );

    // More than one hit bit set means two ports targeted this entry.
    assign w_multi[e] = |(w_hit[e] & (w_hit[e] - N_WR'(1)));
  end

  // NOTE: the storage array is reset because reset must read back as all-zero entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < N_ENTRIES; e++) r_mem[e] <= '0;
      r_conflict <= 1'b0;
    end else begin
      for (int e = 0; e < N_ENTRIES; e++) r_mem[e] <= w_next[e];
      r_conflict <= |w_multi;
    end
  end

  assign wr_conflict = r_conflict;

  // Write-first reads take the post-edge value, read-first the stored one.
  always_comb begin
    w_rd_val = '0;
    for (int r = 0; r < N_RD; r++) begin
      for (int e = 0; e < N_ENTRIES; e++) begin
        if (rd_addr[r] == AW'(e)) w_rd_val[r] = (BYPASS != 0) ? w_next[e] : r_mem[e];
      end
    end
  end

  if (LAT == RD_REG) begin : g_rd_reg
    logic [N_RD-1:0][DWIDTH-1:0] r_rd_data;
    logic [N_RD-1:0]             r_rd_valid;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rd_data  <= '0;
        r_rd_valid <= '0;
      end else begin
        r_rd_valid <= rd_en;
        for (int r = 0; r < N_RD; r++) begin
          if (rd_en[r]) r_rd_data[r] <= w_rd_val[r];
        end
      end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
  end else begin : g_rd_comb
    assign rd_data  = w_rd_val;
    assign rd_valid = rd_en;
  end

endmodule
